// File: rtl/morse_pkg.sv
// Shared definitions for the Morse encoder: symbol codes, FSM states,
// timing multipliers and the ASCII range handled by the code ROM.
package morse_pkg;

    typedef enum logic [2:0] {
        IDLE,
        MARK,
        ELEM_GAP,
        LETTER_GAP,
        WORD_GAP
    } state_t;

    localparam logic [1:0] SYM_NONE = 2'b00;
    localparam logic [1:0] SYM_DOT  = 2'b01;
    localparam logic [1:0] SYM_DASH = 2'b10;
    localparam logic [1:0] SYM_SEND = 2'b11;

    localparam int MULT_DOT        = 1;
    localparam int MULT_DASH       = 3;
    localparam int MULT_ELEM_GAP   = 1;
    localparam int MULT_LETTER_GAP = 3;
    localparam int MULT_WORD_GAP   = 7;

    localparam logic [7:0] ASCII_SPACE = 8'd32;
    localparam logic [7:0] ASCII_A     = 8'd65;
    localparam logic [7:0] ASCII_Z     = 8'd90;

endpackage

// File: rtl/morse_code_rom.sv
// Combinational ITU Morse lookup for 'A'..'Z'. The code sits in the low
// len bits of pattern, first element in bit len-1; 1 = dash, 0 = dot.
module morse_code_rom
    import morse_pkg::*;
(
    input  logic [7:0] ascii,
    output logic [3:0] pattern,
    output logic [2:0] len,
    output logic       valid
);

    always_comb begin
        pattern = 4'b0000;
        len     = 3'd0;
        valid   = (ascii >= ASCII_A) && (ascii <= ASCII_Z);
        case (ascii)
            8'd65: begin pattern = 4'b0001; len = 3'd2; end // A .-
            8'd66: begin pattern = 4'b1000; len = 3'd4; end // B -...
            8'd67: begin pattern = 4'b1010; len = 3'd4; end // C -.-.
            8'd68: begin pattern = 4'b0100; len = 3'd3; end // D -..
            8'd69: begin pattern = 4'b0000; len = 3'd1; end // E .
            8'd70: begin pattern = 4'b0010; len = 3'd4; end // F ..-.
            8'd71: begin pattern = 4'b0110; len = 3'd3; end // G --.
            8'd72: begin pattern = 4'b0000; len = 3'd4; end // H ....
            8'd73: begin pattern = 4'b0000; len = 3'd2; end // I ..
            8'd74: begin pattern = 4'b0111; len = 3'd4; end // J .---
            8'd75: begin pattern = 4'b0101; len = 3'd3; end // K -.-
            8'd76: begin pattern = 4'b0100; len = 3'd4; end // L .-..
            8'd77: begin pattern = 4'b0011; len = 3'd2; end // M --
            8'd78: begin pattern = 4'b0010; len = 3'd2; end // N -.
            8'd79: begin pattern = 4'b0111; len = 3'd3; end // O ---
            8'd80: begin pattern = 4'b0110; len = 3'd4; end // P .--.
            8'd81: begin pattern = 4'b1101; len = 3'd4; end // Q --.-
            8'd82: begin pattern = 4'b0010; len = 3'd3; end // R .-.
            8'd83: begin pattern = 4'b0000; len = 3'd3; end // S ...
            8'd84: begin pattern = 4'b0001; len = 3'd1; end // T -
            8'd85: begin pattern = 4'b0001; len = 3'd3; end // U ..-
            8'd86: begin pattern = 4'b0001; len = 3'd4; end // V ...-
            8'd87: begin pattern = 4'b0011; len = 3'd3; end // W .--
            8'd88: begin pattern = 4'b1001; len = 3'd4; end // X -..-
            8'd89: begin pattern = 4'b1011; len = 3'd4; end // Y -.--
            8'd90: begin pattern = 4'b1100; len = 3'd4; end // Z --..
            default: begin pattern = 4'b0000; len = 3'd0; end
        endcase
    end

endmodule

// File: rtl/morse_encoder.sv
// Morse keyer: accepts one ASCII character at a time and produces the
// keying waveform plus per-element and end-of-letter symbol strobes.
//
// state      | meaning
// IDLE       | ready for a character
// MARK       | key on for one dot or dash
// ELEM_GAP   | 1-unit silence between elements of a letter
// LETTER_GAP | 3-unit silence after the last element; send strobe at its end
// WORD_GAP   | 7-unit silence for a space character
module morse_encoder
    import morse_pkg::*;
#(
    parameter int UNIT_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] letter,
    input  logic       letter_valid,
    output logic       letter_ready,
    output logic       key_out,
    output logic [1:0] sym_out,
    output logic       busy,
    output logic       error
);

    localparam int CW = $clog2(MULT_WORD_GAP * UNIT_CYCLES);

    localparam logic [CW-1:0] LOAD_DOT    = CW'(MULT_DOT * UNIT_CYCLES - 1);
    localparam logic [CW-1:0] LOAD_DASH   = CW'(MULT_DASH * UNIT_CYCLES - 1);
    localparam logic [CW-1:0] LOAD_ELEM   = CW'(MULT_ELEM_GAP * UNIT_CYCLES - 1);
    localparam logic [CW-1:0] LOAD_LETTER = CW'(MULT_LETTER_GAP * UNIT_CYCLES - 1);
    localparam logic [CW-1:0] LOAD_WORD   = CW'(MULT_WORD_GAP * UNIT_CYCLES - 1);

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [3:0]    pat, pat_n;
    logic [2:0]    len, len_n;
    logic [2:0]    idx, idx_n;
    logic          key_n;
    logic [1:0]    sym_n;
    logic          err_n;

    logic [3:0]    rom_pat;
    logic [2:0]    rom_len;
    logic          rom_valid;
    logic [1:0]    sel;
    logic [1:0]    rom_sel;
    logic          cur_dash;
    logic          rom_first_dash;
    logic [2:0]    idx_inc;

    morse_code_rom u_rom (
        .ascii   (letter),
        .pattern (rom_pat),
        .len     (rom_len),
        .valid   (rom_valid)
    );

    // Elements are consumed from bit len-1 downwards
    assign sel            = 2'(len - idx - 3'd1);
    assign rom_sel        = 2'(rom_len - 3'd1);
    assign cur_dash       = pat[sel];
    assign rom_first_dash = rom_pat[rom_sel];
    assign idx_inc        = idx + 3'd1;

    assign letter_ready = (state == IDLE);
    assign busy         = (state != IDLE);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        pat_n   = pat;
        len_n   = len;
        idx_n   = idx;
        key_n   = 1'b0;
        sym_n   = SYM_NONE;
        err_n   = 1'b0;
        case (state)
            IDLE: begin
                if (letter_valid) begin
                    if (rom_valid) begin
                        pat_n   = rom_pat;
                        len_n   = rom_len;
                        idx_n   = 3'd0;
                        cnt_n   = rom_first_dash ? LOAD_DASH : LOAD_DOT;
                        key_n   = 1'b1;
                        state_n = MARK;
                    end else if (letter == ASCII_SPACE) begin
                        cnt_n   = LOAD_WORD;
                        state_n = WORD_GAP;
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            MARK: begin
                if (cnt == '0) begin
                    sym_n = cur_dash ? SYM_DASH : SYM_DOT;
                    idx_n = idx_inc;
                    if (idx_inc < len) begin
                        cnt_n   = LOAD_ELEM;
                        state_n = ELEM_GAP;
                    end else begin
                        cnt_n   = LOAD_LETTER;
                        state_n = LETTER_GAP;
                    end
                end else begin
                    cnt_n = cnt - 1'b1;
                    key_n = 1'b1;
                end
            end
            ELEM_GAP: begin
                if (cnt == '0) begin
                    cnt_n   = cur_dash ? LOAD_DASH : LOAD_DOT;
                    key_n   = 1'b1;
                    state_n = MARK;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            LETTER_GAP: begin
                if (cnt == '0) begin
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt - 1'b1;
                    // Registered strobe lands on the final gap cycle
                    if (cnt == CW'(1)) sym_n = SYM_SEND;
                end
            end
            WORD_GAP: begin
                if (cnt == '0) state_n = IDLE;
                else           cnt_n   = cnt - 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            pat     <= 4'b0000;
            len     <= 3'd0;
            idx     <= 3'd0;
            key_out <= 1'b0;
            sym_out <= SYM_NONE;
            error   <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            pat     <= pat_n;
            len     <= len_n;
            idx     <= idx_n;
            key_out <= key_n;
            sym_out <= sym_n;
            error   <= err_n;
        end
    end

endmodule

// File: tb/tb_morse_encoder.sv
// Self-checking bench for morse_encoder with UNIT_CYCLES=2; expected
// waveforms are built from dot/dash strings and the unit timing rules.
module tb_morse_encoder;

    localparam int U = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] letter;
    logic       letter_valid;
    logic       letter_ready;
    logic       key_out;
    logic [1:0] sym_out;
    logic       busy;
    logic       error;

    morse_encoder #(.UNIT_CYCLES(U)) dut (
        .clk          (clk),
        .reset        (reset),
        .letter       (letter),
        .letter_valid (letter_valid),
        .letter_ready (letter_ready),
        .key_out      (key_out),
        .sym_out      (sym_out),
        .busy         (busy),
        .error        (error)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // {error, key_out, sym_out, busy, letter_ready} per cycle after accept
    logic [5:0] exp_q[$];
    logic [1:0] sym_log[$];

    string morse[26] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....",
                         "..", ".---", "-.-", ".-..", "--", "-.", "---", ".--.",
                         "--.-", ".-.", "...", "-", "..-", "...-", ".--", "-..-",
                         "-.--", "--.."};

    function automatic logic [5:0] pk(input bit e, input bit k, input logic [1:0] s, input bit b);
        return {e, k, s, b, ~b};
    endfunction

    task automatic build_expected(input logic [7:0] c);
        exp_q.delete();
        if (c >= 8'd65 && c <= 8'd90) begin
            string m;
            m = morse[c - 8'd65];
            for (int i = 0; i < m.len(); i++) begin
                bit dash;
                bit last;
                int gc;
                dash = (m[i] == 8'h2D);
                last = (i == m.len() - 1);
                for (int j = 0; j < (dash ? 3 : 1) * U; j++) exp_q.push_back(pk(0, 1, 2'b00, 1));
                gc = last ? 3 * U : U;
                for (int j = 0; j < gc; j++) begin
                    logic [1:0] s;
                    s = 2'b00;
                    if (j == 0)                 s = dash ? 2'b10 : 2'b01;
                    else if (last && j == gc-1) s = 2'b11;
                    exp_q.push_back(pk(0, 0, s, 1));
                end
            end
            exp_q.push_back(pk(0, 0, 2'b00, 0));
        end else if (c == 8'd32) begin
            for (int j = 0; j < 7 * U; j++) exp_q.push_back(pk(0, 0, 2'b00, 1));
            exp_q.push_back(pk(0, 0, 2'b00, 0));
        end else begin
            exp_q.push_back(pk(1, 0, 2'b00, 0));
            exp_q.push_back(pk(0, 0, 2'b00, 0));
        end
    endtask

    // Must be entered just after a negedge with the DUT idle.
    task automatic run_letter(input logic [7:0] c, input bit hold);
        logic [5:0] obs;
        build_expected(c);
        letter       = c;
        letter_valid = 1'b1;
        @(posedge clk);
        #1;
        if (hold) letter = 8'($urandom_range(65, 90));
        else      letter_valid = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            obs = {error, key_out, sym_out, busy, letter_ready};
            if (sym_out != 2'b00) sym_log.push_back(sym_out);
            n_tests++;
            if (obs !== exp_q[i]) begin
                n_fail++;
                $display("FAIL char%0d cycle %0d: got %b expected %b (err,key,sym,busy,ready)",
                         c, i + 1, obs, exp_q[i]);
            end
        end
    endtask

    task automatic test_reset;
        reset        = 1'b1;
        letter       = 8'd0;
        letter_valid = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++;
        if ({error, key_out, sym_out, busy, letter_ready} !== 6'b000001) begin
            n_fail++;
            $display("FAIL reset_state: got %b expected 000001",
                     {error, key_out, sym_out, busy, letter_ready});
        end
        reset = 1'b0;
    endtask

    task automatic test_directed;
        run_letter(8'd69, 1'b0);
        run_letter(8'd65, 1'b0);
        run_letter(8'd32, 1'b0);
        run_letter(8'd35, 1'b0);
        run_letter(8'd90, 1'b0);
    endtask

    task automatic test_reset_mid_letter;
        logic [1:0] exp_s[4] = '{2'b01, 2'b01, 2'b01, 2'b11};
        letter       = 8'd84;
        letter_valid = 1'b1;
        @(posedge clk);
        #1 letter_valid = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if (key_out !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_T_key: got %b expected 1", key_out);
        end
        reset = 1'b1;
        #1;
        n_tests++;
        if ({error, key_out, sym_out, busy, letter_ready} !== 6'b000001) begin
            n_fail++;
            $display("FAIL async_reset: got %b expected 000001",
                     {error, key_out, sym_out, busy, letter_ready});
        end
        @(negedge clk);
        reset = 1'b0;
        sym_log.delete();
        run_letter(8'd83, 1'b0);
        n_tests++;
        if (sym_log.size() != 4 || sym_log[0] !== exp_s[0] || sym_log[1] !== exp_s[1] ||
            sym_log[2] !== exp_s[2] || sym_log[3] !== exp_s[3]) begin
            n_fail++;
            $display("FAIL after_reset_S: got %0d symbols, required 01,01,01,11", sym_log.size());
        end
    endtask

    task automatic test_back_to_back;
        logic [1:0] exp_s[12] = '{2'b01, 2'b01, 2'b01, 2'b11, 2'b10, 2'b10,
                                  2'b10, 2'b11, 2'b01, 2'b01, 2'b01, 2'b11};
        bit ok;
        sym_log.delete();
        run_letter(8'd83, 1'b1);
        run_letter(8'd79, 1'b1);
        run_letter(8'd83, 1'b1);
        letter_valid = 1'b0;
        ok = (sym_log.size() == 12);
        for (int i = 0; i < 12 && ok; i++) if (sym_log[i] !== exp_s[i]) ok = 1'b0;
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL sos_symbols: got %0d symbols (first %b), required 12 starting 01",
                     sym_log.size(), sym_log.size() > 0 ? sym_log[0] : 2'b00);
        end
    endtask

    task automatic test_random;
        for (int n = 0; n < 30; n++) begin
            int r;
            logic [7:0] c;
            r = int'($urandom_range(0, 9));
            if (r == 0) c = 8'd32;
            else if (r == 1) begin
                c = 8'($urandom_range(0, 255));
                while ((c >= 8'd65 && c <= 8'd90) || c == 8'd32) c = 8'($urandom_range(0, 255));
            end else c = 8'($urandom_range(65, 90));
            run_letter(c, 1'b0);
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                n_tests++;
                if ({error, key_out, sym_out, busy, letter_ready} !== 6'b000001) begin
                    n_fail++;
                    $display("FAIL idle_between: got %b expected 000001",
                             {error, key_out, sym_out, busy, letter_ready});
                end
            end
        end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_reset_mid_letter;
        test_back_to_back;
        test_random;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
